noc_input_buffer: RTL and testbench
===================================

Name: noc_input_buffer

Overview:
- Per-input-port flit buffer of the mesh router; sits directly upstream of the route calculator and input controller.
- Stores incoming flits in a FIFO and tracks packet framing.
- Extracts and holds the head-flit destination fields (drid_x, drid_y, outbound) for the whole packet.
- Returns one credit per freed slot to the upstream router.

Parameters:
- FLIT_W, 32, flit width in bits. Minimum 22.
- DEPTH, 4, FIFO entries. Power of two, ≥2. Equals the credit count granted upstream.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_flit  in  FLIT_W  incoming flit from link
- in_valid  in  1  flit present on in_flit this cycle. No backpressure; credit-based.
- credit_out  out  1  one-cycle pulse per freed slot, to upstream
- out_flit  out  FLIT_W  front flit, to crossbar
- out_valid  out  1  front flit may be consumed
- out_ready  in  1  consumer pops the front flit when out_valid&&out_ready
- drid_x  out  4  held destination X of current packet
- drid_y  out  4  held destination Y of current packet
- outbound  out  1  held outbound bit of current packet
- route_valid  out  1  drid_x/drid_y/outbound valid for current packet
- err  out  1  sticky error: overflow or framing violation

Behaviour:
- Flit format:
  - [FLIT_W-1:FLIT_W-2] type: 00 body, 01 head, 10 tail, 11 single (head+tail).
  - Head/single flits also carry: [FLIT_W-3:FLIT_W-6] drid_x, [FLIT_W-7:FLIT_W-10] drid_y, [FLIT_W-11] outbound.
- Reset (rst high at a clk edge):
  - Pointers, count and FSM are cleared; FSM goes to IDLE.
  - drid_x, drid_y, outbound, route_valid, out_valid, credit_out and err are all 0.
  - Stored flits are discarded and no credits are returned for them. A reset mid-packet behaves identically.
- Write:
  - in_valid with count<DEPTH: the flit is written at the tail.
  - in_valid with count==DEPTH and no pop in the same cycle: the flit is dropped, err is set.
  - Push and pop in the same cycle while full: the flit is accepted.
- No bypass: a flit written at edge N is visible at the front no earlier than after edge N.
- FSM states: IDLE, ROUTED, BODY.
  - IDLE, front flit is head/single: latch drid_x, drid_y, outbound from the front flit; go to ROUTED.
  - IDLE, front flit is body/tail: framing error. Pop the flit internally, set err, pulse credit, stay in IDLE.
  - IDLE, FIFO empty: remain in IDLE.
  - ROUTED: route_valid=1 and out_valid=1. On pop of a head flit, go to BODY. On pop of a single flit, go to IDLE and clear route_valid.
  - BODY: route_valid=1, out_valid=(count>0). Pop of a tail flit goes to IDLE. A head/single flit at the front while in BODY is a framing error: it is popped internally and err is set.
- out_valid is 0 in IDLE. Head latency from write to out_valid is therefore 2 cycles minimum.
- Route fields:
  - Registered and stable from ROUTED until the cycle after the tail/single pop.
  - Cleared to 0 on return to IDLE.
  - route_valid drops the cycle after the tail/single pop.
- Credits: credit_out is registered and pulses 1 cycle after each pop, whether consumer-driven or error-driven. Exactly one pulse per popped flit.
- Back-to-back packets: after a tail pop the FSM is in IDLE for one cycle, then re-routes. This is a 1-cycle bubble per packet.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- out_flit is the front entry and is undefined when count==0.

Decomposition:
- params.vh gains:
  - FLIT_W default.
  - Flit type encodings FT_BODY/FT_HEAD/FT_TAIL/FT_SINGLE.
  - Field-position macros for type, drid_x, drid_y, outbound.
  - Existing CN is unchanged.
- One sub-module: flit_fifo. It holds the storage, pointers, count, full and empty. noc_input_buffer holds the FSM, field latch, credit register and err.

Test Plan:
- Single flit (type 11, drid_x=3, drid_y=1, outbound=0) written, out_ready=1 → out_valid 2 cycles after write; route_valid=1 with drid_x=3, drid_y=1 for 1 cycle; one credit_out pulse the cycle after the pop; IDLE afterwards.
- 4-flit packet head(drid 2,5,outbound=1)/body/body/tail written back-to-back, out_ready held 0 for 5 cycles then 1 → drids held constant throughout; 4 pops on consecutive cycles; 4 credit pulses; route_valid drops after the tail.
- DEPTH=4 filled, then a 5th in_valid with no pop → flit dropped, err=1 and stays 1; count stays 4.
- Full FIFO, in_valid and pop in the same cycle → accepted, count stays 4, no err.
- Body flit arriving in IDLE → popped internally, err=1, one credit pulse, no out_valid.
- rst asserted in BODY with 3 flits stored → next cycle count=0, route_valid=0, out_valid=0, no credits; a new head is accepted normally afterwards.

Source files
------------

// File: rtl/noc_input_buffer_pkg.sv
// noc_input_buffer_pkg
//   Shared types and constants for the router input buffer.
//   - FLIT_W_DEF : default flit width
//   - flit_type_t: two-bit flit type held in the top bits of every flit
//   - state_t    : packet framing FSM states
//   - *_OFS      : field LSB positions, expressed as offsets down from FLIT_W
package noc_input_buffer_pkg;

  localparam int FLIT_W_DEF = 32;
  localparam int DRID_W     = 4;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUTED = 2'd1,
    ST_BODY   = 2'd2
  } state_t;

  // Field LSB = FLIT_W - <offset>
  localparam int TYPE_OFS = 2;   // type   [FLIT_W-1 : FLIT_W-2]
  localparam int DX_OFS   = 6;   // drid_x [FLIT_W-3 : FLIT_W-6]
  localparam int DY_OFS   = 10;  // drid_y [FLIT_W-7 : FLIT_W-10]
  localparam int OB_OFS   = 11;  // outbound bit FLIT_W-11

  // Head and single flits both start a packet and carry route fields.
  function automatic logic opens_packet(input flit_type_t ft);
    return (ft == FT_HEAD) || (ft == FT_SINGLE);
  endfunction

endpackage

// File: rtl/noc_input_buffer_flit_fifo.sv
// flit_fifo
//   Circular flit store with pointers, occupancy count and full/empty flags.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset (pointers/count)
//     push, wr_data   : write request and data; honoured when not full, or
//                       when a pop happens in the same cycle
//     pop             : remove front entry (ignored when empty)
//     rd_data         : front entry (meaningless when empty)
//     full, empty     : occupancy flags
module flit_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_COUNT);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts when the front leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // Front entry is read straight from the array: the FSM must inspect the
  // flit type in the same cycle it decides whether to pop.
  assign rd_data = mem[rd_ptr_reg];

  // Storage has no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/noc_input_buffer.sv
// noc_input_buffer
//   Per-input-port flit buffer: FIFO storage, packet framing FSM, held route
//   fields for the current packet, credit return and sticky error flag.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     in_flit, in_valid : incoming link flit (no backpressure, credit based)
//     credit_out        : one-cycle pulse per freed slot, registered
//     out_flit          : front flit to crossbar
//     out_valid         : front flit may be consumed
//     out_ready         : consumer pops when out_valid && out_ready
//     drid_x, drid_y    : held destination of the current packet
//     outbound          : held outbound bit of the current packet
//     route_valid       : route fields valid
//     err               : sticky overflow / framing error
module noc_input_buffer
  import noc_input_buffer_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              credit_out,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        drid_x,
  output logic [3:0]        drid_y,
  output logic              outbound,
  output logic              route_valid,
  output logic              err
);

  localparam int TYPE_LSB = FLIT_W - TYPE_OFS;
  localparam int DX_LSB   = FLIT_W - DX_OFS;
  localparam int DY_LSB   = FLIT_W - DY_OFS;
  localparam int OB_BIT   = FLIT_W - OB_OFS;

  logic [FLIT_W-1:0] front;
  logic              full, empty;
  logic              push, pop;
  flit_type_t        front_type;

  state_t            state_reg, state_next;
  logic [3:0]        drid_x_reg, drid_x_next;
  logic [3:0]        drid_y_reg, drid_y_next;
  logic              outbound_reg, outbound_next;
  logic              credit_reg;
  logic              err_reg;
  logic              valid_comb;
  logic              frame_err;
  logic              overflow;

  flit_fifo #(
    .W     (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (in_flit),
    .pop     (pop),
    .rd_data (front),
    .full    (full),
    .empty   (empty)
  );

  assign front_type = flit_type_t'(front[FLIT_W-1:TYPE_LSB]);

  always_comb begin
    state_next    = state_reg;
    drid_x_next   = drid_x_reg;
    drid_y_next   = drid_y_reg;
    outbound_next = outbound_reg;
    valid_comb    = 1'b0;
    frame_err     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!empty) begin
          if (opens_packet(front_type)) begin
            drid_x_next   = front[DX_LSB +: 4];
            drid_y_next   = front[DY_LSB +: 4];
            outbound_next = front[OB_BIT];
            state_next    = ST_ROUTED;
          end else begin
            // Orphan body/tail: discard it so the port cannot wedge.
            frame_err = 1'b1;
          end
        end
      end
      ST_ROUTED: begin
        // Front is the head/single flit the route fields came from.
        valid_comb = 1'b1;
        if (out_ready) begin
          if (front_type == FT_SINGLE) begin
            state_next    = ST_IDLE;
            drid_x_next   = '0;
            drid_y_next   = '0;
            outbound_next = 1'b0;
          end else begin
            state_next = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        if (!empty) begin
          if (opens_packet(front_type)) begin
            // A new packet start inside a packet is dropped, not forwarded.
            frame_err = 1'b1;
          end else begin
            valid_comb = 1'b1;
            if (out_ready && (front_type == FT_TAIL)) begin
              state_next    = ST_IDLE;
              drid_x_next   = '0;
              drid_y_next   = '0;
              outbound_next = 1'b0;
            end
          end
        end
      end
      default: begin
        state_next    = ST_IDLE;
        drid_x_next   = '0;
        drid_y_next   = '0;
        outbound_next = 1'b0;
      end
    endcase
  end

  assign pop      = (valid_comb && out_ready) || frame_err;
  assign push     = in_valid;
  assign overflow = in_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      drid_x_reg   <= '0;
      drid_y_reg   <= '0;
      outbound_reg <= 1'b0;
      credit_reg   <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      drid_x_reg   <= drid_x_next;
      drid_y_reg   <= drid_y_next;
      outbound_reg <= outbound_next;
      credit_reg   <= pop;
      err_reg      <= err_reg | frame_err | overflow;
    end
  end

  assign out_flit    = front;
  assign out_valid   = valid_comb;
  assign credit_out  = credit_reg;
  assign drid_x      = drid_x_reg;
  assign drid_y      = drid_y_reg;
  assign outbound    = outbound_reg;
  assign route_valid = (state_reg != ST_IDLE);
  assign err         = err_reg;

endmodule

// File: tb/tb_noc_input_buffer.sv
module tb_noc_input_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_flit;
  logic        in_valid;
  logic        credit_out;
  logic [31:0] out_flit;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  drid_x, drid_y;
  logic        outbound;
  logic        route_valid;
  logic        err;

  always #5 clk = ~clk;

  noc_input_buffer #(.FLIT_W(32), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_flit     (in_flit),
    .in_valid    (in_valid),
    .credit_out  (credit_out),
    .out_flit    (out_flit),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .drid_x      (drid_x),
    .drid_y      (drid_y),
    .outbound    (outbound),
    .route_valid (route_valid),
    .err         (err)
  );

  typedef struct {
    logic [31:0] flit;
    logic [3:0]  dx;
    logic [3:0]  dy;
    logic        ob;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   credit_seen = 0;
  int   c0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [3:0] x,
                                     input logic [3:0] y, input logic ob,
                                     input logic [20:0] pl);
    return {t, x, y, ob, pl};
  endfunction

  task automatic expect_flit(input logic [31:0] f, input logic [3:0] x,
                             input logic [3:0] y, input logic ob);
    exp_t e;
    e.flit = f; e.dx = x; e.dy = y; e.ob = ob;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] f);
    in_flit  = f;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, exp_q.size(), 0);
    tick();
    tick();
  endtask

  // Monitor: scoreboard of consumer pops plus credit pulse counting.
  always @(negedge clk) begin
    if (!rst) begin
      if (credit_out) credit_seen++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop got=%0h exp=none", out_flit);
        end else begin
          mon_e = exp_q.pop_front();
          $display("pop flit=%08h drid=(%0d,%0d) ob=%0d", out_flit, drid_x, drid_y, outbound);
          chk("pop_flit", out_flit, mon_e.flit);
          chk("pop_drid_x", {28'd0, drid_x}, {28'd0, mon_e.dx});
          chk("pop_drid_y", {28'd0, drid_y}, {28'd0, mon_e.dy});
          chk("pop_outbound", {31'd0, outbound}, {31'd0, mon_e.ob});
          chk("pop_route_valid", {31'd0, route_valid}, 32'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] f;
    rst = 1'b1; in_valid = 1'b0; in_flit = '0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_route_valid", {31'd0, route_valid}, 32'd0);
    chk("rst_credit", {31'd0, credit_out}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_drid_x", {28'd0, drid_x}, 32'd0);
    tick();

    // Single flit, exact latency and credit timing.
    out_ready = 1'b1;
    c0 = credit_seen;
    f = mk(2'b11, 4'd3, 4'd1, 1'b0, 21'h1A5);
    expect_flit(f, 4'd3, 4'd1, 1'b0);
    send(f);
    @(negedge clk);
    chk("t1_no_bypass", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_drid_x", {28'd0, drid_x}, 32'd3);
    chk("t1_drid_y", {28'd0, drid_y}, 32'd1);
    @(negedge clk);
    chk("t1_credit_pulse", {31'd0, credit_out}, 32'd1);
    chk("t1_route_drop", {31'd0, route_valid}, 32'd0);
    chk("t1_idle_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t1_credits", credit_seen - c0, 1);

    // Four-flit packet held then streamed.
    out_ready = 1'b0;
    c0 = credit_seen;
    expect_flit(mk(2'b01, 4'd2, 4'd5, 1'b1, 21'h11), 4'd2, 4'd5, 1'b1);
    expect_flit(mk(2'b00, 4'd9, 4'd9, 1'b0, 21'h22), 4'd2, 4'd5, 1'b1);
    expect_flit(mk(2'b00, 4'd7, 4'd0, 1'b1, 21'h33), 4'd2, 4'd5, 1'b1);
    expect_flit(mk(2'b10, 4'd1, 4'd1, 1'b0, 21'h44), 4'd2, 4'd5, 1'b1);
    for (int i = 0; i < 4; i++) send(exp_q[i].flit);
    repeat (5) tick();
    chk("t2_hold_route_valid", {31'd0, route_valid}, 32'd1);
    chk("t2_hold_drid_y", {28'd0, drid_y}, 32'd5);
    chk("t2_hold_outbound", {31'd0, outbound}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_consecutive_valid", {31'd0, out_valid}, 32'd1);
    end
    @(negedge clk);
    chk("t2_route_drop", {31'd0, route_valid}, 32'd0);
    chk("t2_drid_clear", {28'd0, drid_x}, 32'd0);
    tick(); tick();
    chk("t2_credits", credit_seen - c0, 4);
    chk("t2_queue_empty", exp_q.size(), 0);

    // Full FIFO with push and pop in the same cycle.
    out_ready = 1'b0;
    c0 = credit_seen;
    expect_flit(mk(2'b01, 4'd4, 4'd4, 1'b0, 21'h55), 4'd4, 4'd4, 1'b0);
    expect_flit(mk(2'b00, 4'd0, 4'd0, 1'b0, 21'h66), 4'd4, 4'd4, 1'b0);
    expect_flit(mk(2'b00, 4'd0, 4'd0, 1'b0, 21'h77), 4'd4, 4'd4, 1'b0);
    expect_flit(mk(2'b00, 4'd0, 4'd0, 1'b0, 21'h88), 4'd4, 4'd4, 1'b0);
    for (int i = 0; i < 4; i++) send(exp_q[i].flit);
    tick(); tick();
    f = mk(2'b10, 4'd0, 4'd0, 1'b0, 21'h99);
    expect_flit(f, 4'd4, 4'd4, 1'b0);
    out_ready = 1'b1;
    send(f);
    out_ready = 1'b0;
    @(negedge clk);
    chk("t4_no_err", {31'd0, err}, 32'd0);
    tick();
    out_ready = 1'b1;
    drain("t4_drain", 20);
    chk("t4_credits", credit_seen - c0, 5);
    chk("t4_err_still_0", {31'd0, err}, 32'd0);

    // Overflow: fifth flit with no pop is dropped.
    out_ready = 1'b0;
    c0 = credit_seen;
    expect_flit(mk(2'b01, 4'd7, 4'd0, 1'b1, 21'hA1), 4'd7, 4'd0, 1'b1);
    expect_flit(mk(2'b00, 4'd0, 4'd0, 1'b0, 21'hA2), 4'd7, 4'd0, 1'b1);
    expect_flit(mk(2'b00, 4'd0, 4'd0, 1'b0, 21'hA3), 4'd7, 4'd0, 1'b1);
    expect_flit(mk(2'b00, 4'd0, 4'd0, 1'b0, 21'hA4), 4'd7, 4'd0, 1'b1);
    for (int i = 0; i < 4; i++) send(exp_q[i].flit);
    chk("t3_pre_err", {31'd0, err}, 32'd0);
    send(mk(2'b10, 4'd0, 4'd0, 1'b0, 21'hA5));
    @(negedge clk);
    chk("t3_err_set", {31'd0, err}, 32'd1);
    repeat (3) tick();
    chk("t3_err_sticky", {31'd0, err}, 32'd1);
    out_ready = 1'b1;
    drain("t3_drain", 20);
    chk("t3_credits", credit_seen - c0, 4);
    chk("t3_body_empty_valid", {31'd0, out_valid}, 32'd0);
    chk("t3_err_after", {31'd0, err}, 32'd1);
    do_reset();
    chk("t3_reset_err", {31'd0, err}, 32'd0);
    chk("t3_reset_route", {31'd0, route_valid}, 32'd0);

    // Orphan body flit in IDLE.
    out_ready = 1'b1;
    c0 = credit_seen;
    send(mk(2'b00, 4'd5, 4'd5, 1'b1, 21'hB0));
    repeat (3) tick();
    chk("t5_err", {31'd0, err}, 32'd1);
    chk("t5_credits", credit_seen - c0, 1);
    chk("t5_route_valid", {31'd0, route_valid}, 32'd0);
    do_reset();

    // Reset mid-packet with three flits stored.
    out_ready = 1'b0;
    expect_flit(mk(2'b01, 4'd6, 4'd3, 1'b0, 21'hC0), 4'd6, 4'd3, 1'b0);
    send(exp_q[0].flit);
    send(mk(2'b00, 4'd0, 4'd0, 1'b0, 21'hC1));
    send(mk(2'b00, 4'd0, 4'd0, 1'b0, 21'hC2));
    send(mk(2'b00, 4'd0, 4'd0, 1'b0, 21'hC3));
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    chk("t6_head_popped", exp_q.size(), 0);
    chk("t6_in_body", {31'd0, route_valid}, 32'd1);
    c0 = credit_seen;
    do_reset();
    @(negedge clk);
    chk("t6_route_valid", {31'd0, route_valid}, 32'd0);
    chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_credit", {31'd0, credit_out}, 32'd0);
    repeat (4) tick();
    chk("t6_no_credits", credit_seen - c0, 0);
    chk("t6_no_err", {31'd0, err}, 32'd0);
    chk("t6_still_empty", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    c0 = credit_seen;
    f = mk(2'b11, 4'd1, 4'd2, 1'b1, 21'hD0);
    expect_flit(f, 4'd1, 4'd2, 1'b1);
    send(f);
    drain("t6_new_head", 20);
    chk("t6_new_credits", credit_seen - c0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
